// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_unit
//  Description : IF-stage PC register and fetch sequencer. Issues word fetches
//                over a req/ack handshake and fills the IF/ID register.
//                Handles stall hold, wrong-path discard, redirects and a
//                one-entry hold buffer.
//  Revision    : 1.0  initial release
// ============================================================================
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        take_jump,
    input  logic [31:0] jump_target,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        misaligned_pc
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_HOLD    = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] next_pc;
    logic [31:0] hold_pc;
    logic [31:0] hold_instr;

    logic [31:0] redirect_pc;
    logic [31:0] redirect_pc_inc;
    logic [31:0] next_pc_inc;
    logic        ack_valid;

    // Redirect target is forced word aligned; a misaligned low pair only flags.
    assign redirect_pc     = {jump_target[31:2], 2'b00};
    assign redirect_pc_inc = redirect_pc + 32'd4;
    assign next_pc_inc     = next_pc + 32'd4;
    // An ack only counts while a request is actually outstanding.
    assign ack_valid       = imem_req & imem_ack;

    // Fetch sequencer: PC, request, IF/ID register and hold buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            next_pc       <= RESET_PC;
            imem_req      <= 1'b0;
            imem_addr     <= RESET_PC;
            if_id_valid   <= 1'b0;
            if_id_pc      <= 32'h0000_0000;
            if_id_instr   <= NOP_INSTR;
            misaligned_pc <= 1'b0;
            hold_pc       <= 32'h0000_0000;
            hold_instr    <= 32'h0000_0000;
        end else begin
            // Single-cycle flag tied to the redirect seen this cycle.
            misaligned_pc <= take_jump && (jump_target[1:0] != 2'b00);

            case (state)
                S_IDLE: begin
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                    if (take_jump) begin
                        imem_addr <= redirect_pc;
                        next_pc   <= redirect_pc_inc;
                    end else begin
                        imem_addr <= next_pc;
                        next_pc   <= next_pc_inc;
                    end
                end

                S_FETCH: begin
                    if (take_jump) begin
                        // The outstanding word is wrong-path either way.
                        if_id_valid <= 1'b0;
                        if (ack_valid) begin
                            imem_addr <= redirect_pc;
                            next_pc   <= redirect_pc_inc;
                        end else begin
                            next_pc <= redirect_pc;
                            state   <= S_DISCARD;
                        end
                    end else if (ack_valid) begin
                        if (!stall) begin
                            if_id_valid <= 1'b1;
                            if_id_pc    <= imem_addr;
                            if_id_instr <= imem_rdata;
                            imem_addr   <= next_pc;
                            next_pc     <= next_pc_inc;
                        end else begin
                            // IF/ID is frozen, so park the word and pause fetch.
                            hold_pc    <= imem_addr;
                            hold_instr <= imem_rdata;
                            imem_req   <= 1'b0;
                            state      <= S_HOLD;
                        end
                    end else if (!stall) begin
                        // Memory still busy: insert a bubble.
                        if_id_valid <= 1'b0;
                    end
                end

                S_HOLD: begin
                    if (take_jump) begin
                        hold_pc     <= 32'h0000_0000;
                        hold_instr  <= 32'h0000_0000;
                        if_id_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        imem_addr   <= redirect_pc;
                        next_pc     <= redirect_pc_inc;
                        state       <= S_FETCH;
                    end else if (!stall) begin
                        if_id_valid <= 1'b1;
                        if_id_pc    <= hold_pc;
                        if_id_instr <= hold_instr;
                        imem_req    <= 1'b1;
                        imem_addr   <= next_pc;
                        next_pc     <= next_pc_inc;
                        state       <= S_FETCH;
                    end
                end

                S_DISCARD: begin
                    // Request stays frozen until memory answers; data is dropped.
                    if (ack_valid) begin
                        state <= S_FETCH;
                        if (take_jump) begin
                            imem_addr <= redirect_pc;
                            next_pc   <= redirect_pc_inc;
                        end else begin
                            imem_addr <= next_pc;
                            next_pc   <= next_pc_inc;
                        end
                    end else if (take_jump) begin
                        next_pc <= redirect_pc;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_fetch_unit
//  Description : Self-checking bench for if_fetch_unit with a variable-latency
//                instruction memory model and fetch/IF-ID scoreboards.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        take_jump = 1'b0;
    logic [31:0] jump_target = 32'h0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        misaligned_pc;

    int n_pass  = 0;
    int n_total = 0;
    int lat     = 0;
    int wcnt    = 0;

    logic [31:0] exp_hs[$];
    logic [31:0] exp_ifid[$];
    logic        have_last = 1'b0;
    logic [31:0] last_pc   = 32'h0;

    if_fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .take_jump    (take_jump),
        .jump_target  (jump_target),
        .stall        (stall),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .if_id_valid  (if_id_valid),
        .if_id_pc     (if_id_pc),
        .if_id_instr  (if_id_instr),
        .misaligned_pc(misaligned_pc)
    );

    always #5 clk = ~clk;

    // Memory model: ack after 'lat' waiting cycles (0 = same cycle as request).
    assign imem_ack   = imem_req && (wcnt >= lat);
    assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

    always @(posedge clk or posedge rst) begin
        if (rst)                        wcnt <= 0;
        else if (imem_req && imem_ack)  wcnt <= 0;
        else if (imem_req)              wcnt <= wcnt + 1;
    end

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        check32({tag, "_req"},   {31'h0, imem_req},      32'h0);
        check32({tag, "_addr"},  imem_addr,              32'h0);
        check32({tag, "_valid"}, {31'h0, if_id_valid},   32'h0);
        check32({tag, "_pc"},    if_id_pc,               32'h0);
        check32({tag, "_instr"}, if_id_instr,            32'h0000_0013);
        check32({tag, "_mis"},   {31'h0, misaligned_pc}, 32'h0);
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (imem_req && imem_ack) begin
                if (exp_hs.size() == 0) begin
                    n_total++;
                    $error("FAIL hs_extra: observed %h expected none", imem_addr);
                end else begin
                    check32("hs_addr", imem_addr, exp_hs.pop_front());
                end
            end
            if (if_id_valid) begin
                if (!have_last || if_id_pc != last_pc) begin
                    if (exp_ifid.size() == 0) begin
                        n_total++;
                        $error("FAIL ifid_extra: observed %h expected none", if_id_pc);
                    end else begin
                        logic [31:0] e;
                        e = exp_ifid.pop_front();
                        check32("ifid_pc", if_id_pc, e);
                        check32("ifid_instr", if_id_instr, e ^ 32'hA5A5_0000);
                    end
                    last_pc   = if_id_pc;
                    have_last = 1'b1;
                end
            end else begin
                have_last = 1'b0;
            end
        end
    end

    initial begin
        int g;
        // ---------------- reset and zero-wait streaming ----------------
        for (int a = 0; a <= 32'h40; a += 4) exp_hs.push_back(32'(a));
        for (int a = 0; a <= 32'h3C; a += 4) exp_ifid.push_back(32'(a));
        rst = 1'b1;
        repeat (2) tick();
        chk_reset("rst0");
        rst = 1'b0;
        tick();
        check32("e1_req",   {31'h0, imem_req},    32'h1);
        check32("e1_addr",  imem_addr,            32'h0);
        check32("e1_valid", {31'h0, if_id_valid}, 32'h0);
        tick();
        check32("e2_valid", {31'h0, if_id_valid}, 32'h1);
        check32("e2_pc",    if_id_pc,             32'h0);
        check32("e2_addr",  imem_addr,            32'h4);
        repeat (3) tick();
        check32("e5_addr",  imem_addr,            32'h10);
        check32("e5_pc",    if_id_pc,             32'hC);

        // ---------------- stall with ack -> HOLD ----------------
        stall = 1'b1;
        tick();
        check32("hold_req", {31'h0, imem_req}, 32'h0);
        check32("hold_pc",  if_id_pc,          32'hC);
        repeat (2) tick();
        check32("hold3_req",   {31'h0, imem_req},    32'h0);
        check32("hold3_pc",    if_id_pc,             32'hC);
        check32("hold3_valid", {31'h0, if_id_valid}, 32'h1);
        stall = 1'b0;
        tick();
        check32("rel_pc",    if_id_pc,          32'h10);
        check32("rel_instr", if_id_instr,       32'hA5A5_0010);
        check32("rel_req",   {31'h0, imem_req}, 32'h1);
        check32("rel_addr",  imem_addr,         32'h14);

        // ---------------- redirect during slow request ----------------
        g = 0;
        while (imem_addr !== 32'h40 && g < 50) begin
            tick();
            g++;
        end
        check32("reach_40", imem_addr, 32'h40);
        exp_hs.push_back(32'h200);
        exp_hs.push_back(32'h204);
        exp_ifid.push_back(32'h200);
        lat = 3;
        take_jump = 1'b1;
        jump_target = 32'h200;
        tick();
        take_jump = 1'b0;
        check32("dA_valid", {31'h0, if_id_valid}, 32'h0);
        check32("dA_addr",  imem_addr,            32'h40);
        check32("dA_req",   {31'h0, imem_req},    32'h1);
        tick();
        check32("dB_addr", imem_addr, 32'h40);
        tick();
        check32("dC_addr", imem_addr, 32'h40);
        tick();
        check32("dD_addr", imem_addr, 32'h200);
        lat = 0;
        tick();
        check32("dE_pc",   if_id_pc,  32'h200);
        check32("dE_addr", imem_addr, 32'h204);

        // ---------------- two redirects while discarding ----------------
        exp_hs.push_back(32'h400);
        exp_hs.push_back(32'h404);
        exp_ifid.push_back(32'h400);
        lat = 3;
        take_jump = 1'b1;
        jump_target = 32'h300;
        tick();
        check32("dF_mis", {31'h0, misaligned_pc}, 32'h0);
        jump_target = 32'h400;
        tick();
        take_jump = 1'b0;
        check32("dG_addr",  imem_addr,            32'h204);
        check32("dG_valid", {31'h0, if_id_valid}, 32'h0);
        tick();
        check32("dH_addr", imem_addr, 32'h204);
        tick();
        check32("dI_addr", imem_addr, 32'h400);
        lat = 0;
        tick();
        check32("dJ_pc",   if_id_pc,  32'h400);
        check32("dJ_addr", imem_addr, 32'h404);

        // ---------------- misaligned redirect with same-cycle ack ----------------
        exp_hs.push_back(32'h100);
        exp_ifid.push_back(32'h100);
        take_jump = 1'b1;
        jump_target = 32'h103;
        tick();
        take_jump = 1'b0;
        check32("mK_mis",   {31'h0, misaligned_pc}, 32'h1);
        check32("mK_addr",  imem_addr,              32'h100);
        check32("mK_valid", {31'h0, if_id_valid},   32'h0);
        tick();
        check32("mL_mis",   {31'h0, misaligned_pc}, 32'h0);
        check32("mL_pc",    if_id_pc,               32'h100);
        check32("mL_addr",  imem_addr,              32'h104);

        // ---------------- async reset mid-DISCARD ----------------
        lat = 3;
        take_jump = 1'b1;
        jump_target = 32'h500;
        tick();
        take_jump = 1'b0;
        #2 rst = 1'b1;
        #1 chk_reset("rst_disc");
        exp_hs.push_back(32'h0);
        exp_hs.push_back(32'h4);
        exp_ifid.push_back(32'h0);
        lat = 0;
        tick();
        rst = 1'b0;
        tick();
        check32("r1_addr", imem_addr, 32'h0);
        tick();
        check32("r2_pc",   if_id_pc,  32'h0);
        check32("r2_addr", imem_addr, 32'h4);

        // ---------------- async reset mid-HOLD ----------------
        stall = 1'b1;
        tick();
        check32("h_req", {31'h0, imem_req}, 32'h0);
        #2 rst = 1'b1;
        #1 chk_reset("rst_hold");
        stall = 1'b0;
        exp_hs.push_back(32'h0);
        exp_hs.push_back(32'hFFFF_FFFC);
        exp_hs.push_back(32'h0);
        exp_ifid.push_back(32'hFFFF_FFFC);
        exp_ifid.push_back(32'h0);
        tick();
        rst = 1'b0;

        // ---------------- PC wrap at top of address space ----------------
        tick();
        check32("w1_addr", imem_addr, 32'h0);
        take_jump = 1'b1;
        jump_target = 32'hFFFF_FFFC;
        tick();
        take_jump = 1'b0;
        check32("w2_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        check32("w3_pc",   if_id_pc,  32'hFFFF_FFFC);
        check32("w3_addr", imem_addr, 32'h0);
        tick();
        check32("w4_pc",   if_id_pc,  32'h0);
        check32("w4_addr", imem_addr, 32'h4);
        lat = 99;
        repeat (3) tick();

        check32("hs_left",   32'(exp_hs.size()),   32'h0);
        check32("ifid_left", 32'(exp_ifid.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
